rst_set_release_seq: RTL and testbench



---
 rtl/rst_set_release_seq_if.sv | 27 ++
 rtl/rst_set_release_seq.sv | 144 ++++++++++++++
 tb/tb_rst_set_release_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rst_set_release_seq_if.sv
// Handshake bundle between the reset/set release sequencer and the flop banks it drives.
// The master side is the sequencer; the slave side is whoever issues software resets and watches the bank pins.
interface rst_set_release_seq_if #(
    parameter int NBANK = 4
);
    logic             SW_RST_REQ;
    logic [NBANK-1:0] BANK_RSTB;
    logic [NBANK-1:0] BANK_SETB;
    logic             BUSY;
    logic             DONE;

    modport master (
        input  SW_RST_REQ,
        output BANK_RSTB,
        output BANK_SETB,
        output BUSY,
        output DONE
    );

    modport slave (
        output SW_RST_REQ,
        input  BANK_RSTB,
        input  BANK_SETB,
        input  BUSY,
        input  DONE
    );
endinterface

// File: rtl/rst_set_release_seq.sv
// Drives per-bank async RSTB/SETB pins: asserts them asynchronously, holds them for a minimum
// pulse width after a synchronized release, then lets the banks go one at a time, staggered.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_SYNC  | master reset seen, waiting for the deassertion synchronizer
// ST_HOLD  | all banks asserted, counting the minimum pulse width
// ST_REL   | releasing banks one by one, STAGGER cycles apart
// ST_IDLE  | every bank released, software reset requests accepted
module rst_set_release_seq #(
    parameter int               NBANK        = 4,
    parameter int               SYNC_STAGES  = 2,
    parameter int               MIN_PW       = 4,
    parameter int               STAGGER      = 2,
    parameter logic [NBANK-1:0] INIT_PATTERN = 4'b0101
) (
    input logic                    CLK,
    input logic                    RSTB,
    rst_set_release_seq_if.master  bus
);
    localparam int HW = $clog2(MIN_PW + 1);
    localparam int SW = $clog2(STAGGER + 1);
    localparam int IW = $clog2(NBANK + 1);

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;
    localparam logic [1:0] ST_IDLE = 2'd3;

    localparam logic [HW-1:0]    HOLD_LOAD  = HW'(MIN_PW - 1);
    localparam logic [SW-1:0]    STG_LOAD   = SW'(STAGGER - 1);
    localparam logic [IW-1:0]    LAST_BANK  = IW'(NBANK - 1);
    // A SET bank (pattern bit 1) holds SETB low; a RESET bank holds RSTB low.
    localparam logic [NBANK-1:0] ASSERT_RSTB = INIT_PATTERN;
    localparam logic [NBANK-1:0] ASSERT_SETB = ~INIT_PATTERN;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             state_q, state_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [SW-1:0]          stg_q, stg_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NBANK-1:0]       bank_rstb_q, bank_rstb_d;
    logic [NBANK-1:0]       bank_setb_q, bank_setb_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        stg_d       = stg_q;
        idx_d       = idx_q;
        bank_rstb_d = bank_rstb_q;
        bank_setb_d = bank_setb_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_SYNC: begin
                // Next edge is the one where the synchronizer output rises; enter HOLD on it.
                if (sync_q[SYNC_STAGES-2] && !sync_q[SYNC_STAGES-1]) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (hold_q == '0) begin
                    bank_rstb_d[0] = 1'b1;
                    bank_setb_d[0] = 1'b1;
                    if (NBANK == 1) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_REL;
                        idx_d   = IW'(1);
                        stg_d   = STG_LOAD;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            ST_REL: begin
                if (stg_q == '0) begin
                    for (int i = 0; i < NBANK; i++) begin
                        if (idx_q == IW'(i)) begin
                            bank_rstb_d[i] = 1'b1;
                            bank_setb_d[i] = 1'b1;
                        end
                    end
                    if (idx_q == LAST_BANK) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        stg_d = STG_LOAD;
                    end
                end else begin
                    stg_d = stg_q - 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.SW_RST_REQ) begin
                    state_d     = ST_HOLD;
                    hold_d      = HOLD_LOAD;
                    idx_d       = '0;
                    stg_d       = '0;
                    bank_rstb_d = ASSERT_RSTB;
                    bank_setb_d = ASSERT_SETB;
                    busy_d      = 1'b1;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            sync_q      <= '0;
            state_q     <= ST_SYNC;
            hold_q      <= '0;
            stg_q       <= '0;
            idx_q       <= '0;
            bank_rstb_q <= ASSERT_RSTB;
            bank_setb_q <= ASSERT_SETB;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], 1'b1};
            state_q     <= state_d;
            hold_q      <= hold_d;
            stg_q       <= stg_d;
            idx_q       <= idx_d;
            bank_rstb_q <= bank_rstb_d;
            bank_setb_q <= bank_setb_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.BANK_RSTB = bank_rstb_q;
    assign bus.BANK_SETB = bank_setb_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
endmodule

// File: tb/tb_rst_set_release_seq.sv
// Directed bench for rst_set_release_seq: default 4-bank instance plus a 1-bank corner instance.
module tb_rst_set_release_seq;
    logic CLK = 1'b0;
    logic RSTB;
    logic RSTB1;
    bit   mon_en = 1'b0;
    int   errs   = 0;
    int   checks = 0;

    rst_set_release_seq_if #(.NBANK(4)) bus0 ();
    rst_set_release_seq_if #(.NBANK(1)) bus1 ();

    rst_set_release_seq #(
        .NBANK(4), .SYNC_STAGES(2), .MIN_PW(4), .STAGGER(2), .INIT_PATTERN(4'b0101)
    ) dut0 (
        .CLK(CLK), .RSTB(RSTB), .bus(bus0)
    );

    rst_set_release_seq #(
        .NBANK(1), .SYNC_STAGES(3), .MIN_PW(1), .STAGGER(1), .INIT_PATTERN(1'b1)
    ) dut1 (
        .CLK(CLK), .RSTB(RSTB1), .bus(bus1)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected pins for edges E0+0 .. E0+11 (releases at +4,+6,+8,+10; DONE at +10).
    logic [3:0] exp_rstb [12] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101,
                                  4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b1111, 4'b1111};
    logic [3:0] exp_setb [12] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1011, 4'b1011,
                                  4'b1011, 4'b1011, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    logic       exp_busy [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic       exp_done [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    always @(bus0.BANK_RSTB or bus0.BANK_SETB) begin
        logic [3:0] both_low;
        both_low = ~bus0.BANK_RSTB & ~bus0.BANK_SETB;
        if (mon_en) chk("excl0", both_low, 0);
    end

    always @(bus1.BANK_RSTB or bus1.BANK_SETB) begin
        logic both_low1;
        both_low1 = ~bus1.BANK_RSTB[0] & ~bus1.BANK_SETB[0];
        if (mon_en) chk("excl1", both_low1, 0);
    end

    // Steps through edges E0..E0+11; the caller arms SW_RST_REQ or RSTB beforehand.
    task automatic check_seq(input string tag, input bit hold_sw);
        for (int o = 0; o < 12; o++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("%s rstb +%0d", tag, o), bus0.BANK_RSTB, exp_rstb[o]);
            chk($sformatf("%s setb +%0d", tag, o), bus0.BANK_SETB, exp_setb[o]);
            chk($sformatf("%s busy +%0d", tag, o), bus0.BUSY, exp_busy[o]);
            chk($sformatf("%s done +%0d", tag, o), bus0.DONE, exp_done[o]);
            if (!hold_sw || o >= 10) bus0.SW_RST_REQ = 1'b0;
        end
    endtask

    task automatic check_asserted(input string tag);
        chk({tag, " rstb"}, bus0.BANK_RSTB, 4'b0101);
        chk({tag, " setb"}, bus0.BANK_SETB, 4'b1010);
        chk({tag, " busy"}, bus0.BUSY, 1'b1);
        chk({tag, " done"}, bus0.DONE, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        RSTB = 1'b0;
        RSTB1 = 1'b0;
        bus0.SW_RST_REQ = 1'b0;
        bus1.SW_RST_REQ = 1'b0;
        #1 mon_en = 1'b1;

        // Reset state of both instances.
        @(posedge CLK);
        #1;
        check_asserted("por reset");
        chk("c1 reset setb", bus1.BANK_SETB, 1'b0);
        chk("c1 reset rstb", bus1.BANK_RSTB, 1'b1);
        chk("c1 reset busy", bus1.BUSY, 1'b1);

        // Power-on: RSTB rises between edge 0 and 1, E0 = edge 2.
        @(posedge CLK);
        #2 RSTB = 1'b1;
        @(posedge CLK);
        #1 check_asserted("por edge1");
        check_seq("por", 1'b0);

        // Software reset from IDLE.
        bus0.SW_RST_REQ = 1'b1;
        check_seq("sw", 1'b0);

        // Request held through HOLD/RELEASE and on the DONE edge: one sequence only.
        bus0.SW_RST_REQ = 1'b1;
        check_seq("swhold", 1'b1);
        @(posedge CLK);
        #1;
        chk("swhold after busy", bus0.BUSY, 1'b0);
        chk("swhold after rstb", bus0.BANK_RSTB, 4'hF);
        chk("swhold after setb", bus0.BANK_SETB, 4'hF);

        // Short RSTB glitch after bank1 has released.
        bus0.SW_RST_REQ = 1'b1;
        repeat (7) begin
            @(posedge CLK);
            #1 bus0.SW_RST_REQ = 1'b0;
        end
        chk("pre-glitch rstb", bus0.BANK_RSTB, 4'b0111);
        chk("pre-glitch setb", bus0.BANK_SETB, 4'b1011);
        #1 RSTB = 1'b0;
        #1 check_asserted("glitch low");
        #2 RSTB = 1'b1;
        #1 check_asserted("glitch high");
        @(posedge CLK);
        #1 check_asserted("glitch edge1");
        check_seq("glitch", 1'b0);

        // Single-bank corner: SYNC_STAGES=3, MIN_PW=1, STAGGER=1, SET bank.
        @(posedge CLK);
        #2 RSTB1 = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("c1 edge%0d setb", e), bus1.BANK_SETB, 1'b0);
            chk($sformatf("c1 edge%0d busy", e), bus1.BUSY, 1'b1);
            chk($sformatf("c1 edge%0d done", e), bus1.DONE, 1'b0);
        end
        @(posedge CLK);
        #1;
        chk("c1 release setb", bus1.BANK_SETB, 1'b1);
        chk("c1 release rstb", bus1.BANK_RSTB, 1'b1);
        chk("c1 release done", bus1.DONE, 1'b1);
        chk("c1 release busy", bus1.BUSY, 1'b0);
        @(posedge CLK);
        #1;
        chk("c1 after done", bus1.DONE, 1'b0);
        chk("c1 after busy", bus1.BUSY, 1'b0);

        // Random requests and RSTB glitches; exclusivity monitors stay armed.
        repeat (300) begin
            @(posedge CLK);
            #1;
            bus0.SW_RST_REQ = 1'($urandom_range(0, 1));
            bus1.SW_RST_REQ = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                #2 RSTB = 1'b0;
                #($urandom_range(1, 4)) RSTB = 1'b1;
            end
        end

        // Clean restart must still follow the power-on timing.
        bus0.SW_RST_REQ = 1'b0;
        bus1.SW_RST_REQ = 1'b0;
        #2 RSTB = 1'b0;
        @(posedge CLK);
        #2 RSTB = 1'b1;
        @(posedge CLK);
        #1 check_asserted("por2 edge1");
        check_seq("por2", 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
